fifo_port_ctrl: RTL and testbench

- Sequencer and arbiter in front of the 4-entry, 8-bit push/pop FIFO.
- Shares the FIFO write port between two producers (A, B) with round-robin arbitration.
- Schedules pops for a single consumer.
- Keeps its own occupancy count, so a registered push or pop is never issued against a full or empty FIFO, and flags any mismatch with the FIFO's full/empty flags.

---
 rtl/fifo_port_ctrl.sv | 135 +++++++++++++
 tb/tb_fifo_port_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_port_ctrl.sv
// fifo_port_ctrl: shares the write port of a small push/pop FIFO between two
// producers (round-robin) and schedules single-word pops for one consumer.
// Keeps its own occupancy count so registered push/pop never overrun the FIFO,
// and raises a sticky flag if that count disagrees with the FIFO's flags.
module fifo_port_ctrl #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         a_req,
    input  logic [DW-1:0]                a_data,
    output logic                         a_gnt,
    input  logic                         b_req,
    input  logic [DW-1:0]                b_data,
    output logic                         b_gnt,
    input  logic                         c_req,
    output logic                         c_valid,
    output logic [DW-1:0]                c_data,
    output logic                         push,
    output logic [DW-1:0]                data_in,
    output logic                         pop,
    input  logic [DW-1:0]                fifo_dout,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    output logic [$clog2(DEPTH+1)-1:0]   occ,
    output logic                         sync_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] OCC_FULL  = CW'(DEPTH);
    localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(DEPTH);

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_t;

    gnt_t last_gnt, last_gnt_next;
    logic space;
    logic avail;

    // Write space counts the push already in flight, closing the fill race.
    assign space = ({1'b0, occ} + (CW + 1)'(push)) < DEPTH_EXT;
    assign avail = (occ != '0);

    // Last-grant register for round-robin fairness.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_gnt <= GNT_B;
        end else begin
            last_gnt <= last_gnt_next;
        end
    end

    // Grant decision and next round-robin state; no grants while in reset.
    always_comb begin
        a_gnt         = 1'b0;
        b_gnt         = 1'b0;
        last_gnt_next = last_gnt;
        if (reset && space) begin
            if (a_req && b_req) begin
                if (last_gnt == GNT_B) begin
                    a_gnt = 1'b1;
                end else begin
                    b_gnt = 1'b1;
                end
            end else if (a_req) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
        if (a_gnt) begin
            last_gnt_next = GNT_A;
        end else if (b_gnt) begin
            last_gnt_next = GNT_B;
        end
    end

    // Write pipeline: a grant becomes a registered push one cycle later.
    always_ff @(posedge clk) begin
        if (!reset) begin
            push    <= 1'b0;
            data_in <= '0;
        end else begin
            push <= a_gnt | b_gnt;
            if (a_gnt) begin
                data_in <= a_data;
            end else if (b_gnt) begin
                data_in <= b_data;
            end
        end
    end

    // Pop scheduling (never back-to-back) and read-data capture.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop     <= 1'b0;
            c_valid <= 1'b0;
            c_data  <= '0;
        end else begin
            pop     <= c_req && avail && !pop;
            c_valid <= pop;
            if (pop) begin
                c_data <= fifo_dout;
            end
        end
    end

    // Occupancy count from completed pushes and pops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            occ <= '0;
        end else begin
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // Sticky consistency check, only while no push/pop is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_err <= 1'b0;
        end else if (!push && !pop &&
                     (((occ == OCC_FULL) != fifo_full) ||
                      ((occ == '0) != fifo_empty))) begin
            sync_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_port_ctrl.sv
// Directed bench for fifo_port_ctrl with a behavioural 4-entry FIFO attached.
module tb_fifo_port_ctrl;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, b_req, c_req;
    logic [7:0] a_data, b_data;
    logic       a_gnt, b_gnt, c_valid, push, pop, sync_err;
    logic [7:0] c_data, data_in, fifo_dout;
    logic       fifo_full, fifo_empty;
    logic [2:0] occ;
    logic       force_empty;

    int total = 0;
    int bad   = 0;

    // Behavioural FIFO, first-word-fall-through read data.
    logic [7:0] mem [4];
    logic [1:0] wr_ptr, rd_ptr;
    logic [2:0] cnt;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push && cnt != 3'd4) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (pop && cnt != 3'd0) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            cnt <= cnt + ((push && cnt != 3'd4) ? 3'd1 : 3'd0)
                       - ((pop && cnt != 3'd0) ? 3'd1 : 3'd0);
        end
    end

    assign fifo_dout  = mem[rd_ptr];
    assign fifo_full  = (cnt == 3'd4);
    assign fifo_empty = (cnt == 3'd0) || force_empty;

    fifo_port_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_data(b_data), .b_gnt(b_gnt),
        .c_req(c_req), .c_valid(c_valid), .c_data(c_data),
        .push(push), .data_in(data_in), .pop(pop),
        .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .occ(occ), .sync_err(sync_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        a_req = 1'b0; b_req = 1'b0; c_req = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Producer A writes n words base, base+1, ... into an empty FIFO.
    task automatic fill(input int n, input logic [7:0] base);
        a_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            a_data = base + 8'(i);
            tick();
        end
        a_req = 1'b0;
        tick();
    endtask

    logic [7:0] vals [4];
    logic [7:0] exp_d;
    logic       exp_a;

    initial begin
        force_empty = 1'b0;
        a_data = 8'h00; b_data = 8'h00;
        reset = 1'b0;
        a_req = 1'b1; b_req = 1'b1; c_req = 1'b1;

        // Reset held with all requests active.
        tick();
        tick();
        chk("rst_push",  32'(push), 0);
        chk("rst_pop",   32'(pop), 0);
        chk("rst_cval",  32'(c_valid), 0);
        chk("rst_occ",   32'(occ), 0);
        chk("rst_agnt",  32'(a_gnt), 0);
        chk("rst_bgnt",  32'(b_gnt), 0);
        chk("rst_serr",  32'(sync_err), 0);
        c_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("first_agnt", 32'(a_gnt), 1);
        chk("first_bgnt", 32'(b_gnt), 0);

        // A alone fills the FIFO.
        do_reset();
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        a_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_data = vals[i];
            #1;
            chk("fill_agnt", 32'(a_gnt), 1);
            tick();
            chk("fill_push", 32'(push), 1);
            chk("fill_din",  32'(data_in), 32'(vals[i]));
        end
        a_data = 8'h55;
        #1;
        chk("fill_race_gnt", 32'(a_gnt), 0);
        tick();
        chk("full_push", 32'(push), 0);
        chk("full_occ",  32'(occ), 4);
        chk("full_flag", 32'(fifo_full), 1);
        chk("full_agnt", 32'(a_gnt), 0);
        tick();
        chk("full_agnt2", 32'(a_gnt), 0);
        chk("full_serr",  32'(sync_err), 0);
        a_req = 1'b0;

        // Round-robin between A and B.
        do_reset();
        a_data = 8'hA0; b_data = 8'hB0;
        a_req = 1'b1; b_req = 1'b1;
        exp_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_agnt", 32'(a_gnt), 32'(exp_a));
            chk("rr_bgnt", 32'(b_gnt), 32'(!exp_a));
            exp_d = exp_a ? a_data : b_data;
            tick();
            chk("rr_din", 32'(data_in), 32'(exp_d));
            if (exp_a) a_data = a_data + 8'h01;
            else       b_data = b_data + 8'h01;
            exp_a = !exp_a;
        end
        #1;
        chk("rr_full_agnt", 32'(a_gnt), 0);
        chk("rr_full_bgnt", 32'(b_gnt), 0);
        a_req = 1'b0; b_req = 1'b0;
        tick();
        chk("rr_occ", 32'(occ), 4);

        // Drain with c_req held.
        do_reset();
        fill(4, 8'h01);
        chk("drain_occ0", 32'(occ), 4);
        c_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("drain_pop1", 32'(pop), 1);
            chk("drain_cv0",  32'(c_valid), 0);
            tick();
            chk("drain_pop0",  32'(pop), 0);
            chk("drain_cval",  32'(c_valid), 1);
            chk("drain_cdata", 32'(c_data), 32'(k + 1));
            chk("drain_occ",   32'(occ), 32'(3 - k));
        end
        tick();
        chk("empty_pop",  32'(pop), 0);
        chk("empty_cval", 32'(c_valid), 0);
        tick();
        chk("empty_pop2", 32'(pop), 0);
        chk("drain_serr", 32'(sync_err), 0);
        c_req = 1'b0;

        // Simultaneous push and pop at occ=2.
        do_reset();
        fill(2, 8'h61);
        a_req = 1'b1; a_data = 8'h70; c_req = 1'b1;
        #1;
        chk("sim_agnt", 32'(a_gnt), 1);
        tick();
        chk("sim_push", 32'(push), 1);
        chk("sim_pop",  32'(pop), 1);
        a_req = 1'b0; c_req = 1'b0;
        tick();
        chk("sim_occ",   32'(occ), 2);
        chk("sim_cval",  32'(c_valid), 1);
        chk("sim_cdata", 32'(c_data), 32'h61);
        chk("sim_serr",  32'(sync_err), 0);

        // Flag fault injection, then reset mid-stream.
        do_reset();
        fill(2, 8'h80);
        force_empty = 1'b1;
        tick();
        chk("serr_set", 32'(sync_err), 1);
        force_empty = 1'b0;
        tick();
        tick();
        chk("serr_sticky", 32'(sync_err), 1);
        a_req = 1'b1; a_data = 8'h90;
        tick();
        a_req = 1'b0;
        tick();
        chk("mid_occ3", 32'(occ), 3);
        a_req = 1'b1; c_req = 1'b1;
        tick();
        chk("mid_push", 32'(push), 1);
        chk("mid_pop",  32'(pop), 1);
        reset = 1'b0;
        tick();
        chk("mrst_occ",  32'(occ), 0);
        chk("mrst_push", 32'(push), 0);
        chk("mrst_pop",  32'(pop), 0);
        chk("mrst_serr", 32'(sync_err), 0);
        chk("mrst_agnt", 32'(a_gnt), 0);
        a_req = 1'b0; c_req = 1'b0;
        reset = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
